// File: rtl/mem_arbiter.sv
// Two-client memory arbiter: round-robin grant between an instruction client and a
// data client, a write-data phase for data-client writes, and tag-routed responses.
module mem_arbiter #(
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = 128,
  parameter int TAG_BITS  = 5,
  parameter int WR_BEATS  = 4
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   ic_req_valid,
  output logic                   ic_req_ready,
  input  logic [ADDR_BITS-1:0]   ic_req_addr,
  input  logic [TAG_BITS-2:0]    ic_req_tag,
  output logic                   ic_resp_valid,
  output logic [TAG_BITS-2:0]    ic_resp_tag,
  output logic [DATA_BITS-1:0]   ic_resp_data,

  input  logic                   dc_req_valid,
  output logic                   dc_req_ready,
  input  logic                   dc_req_rw,
  input  logic [ADDR_BITS-1:0]   dc_req_addr,
  input  logic [TAG_BITS-2:0]    dc_req_tag,
  input  logic                   dc_req_data_valid,
  output logic                   dc_req_data_ready,
  input  logic [DATA_BITS-1:0]   dc_req_data_bits,
  input  logic [DATA_BITS/8-1:0] dc_req_data_mask,
  output logic                   dc_resp_valid,
  output logic [TAG_BITS-2:0]    dc_resp_tag,
  output logic [DATA_BITS-1:0]   dc_resp_data,

  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_rw,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic [TAG_BITS-1:0]    mem_req_tag,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  input  logic [TAG_BITS-1:0]    mem_resp_tag,
  input  logic [DATA_BITS-1:0]   mem_resp_data
);

  localparam int CNT_BITS = (WR_BEATS > 1) ? $clog2(WR_BEATS) : 1;
  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(WR_BEATS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    WDATA = 1'b1
  } state_t;

  state_t              state, state_next;
  logic                rr, rr_next;
  logic [CNT_BITS-1:0] beat_cnt, beat_cnt_next;
  logic                grant_dc;
  logic                req_valid;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr       <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      rr       <= rr_next;
      beat_cnt <= beat_cnt_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next         = state;
    rr_next            = rr;
    beat_cnt_next      = beat_cnt;
    ic_req_ready       = 1'b0;
    dc_req_ready       = 1'b0;
    mem_req_valid      = 1'b0;
    mem_req_data_valid = 1'b0;
    dc_req_data_ready  = 1'b0;

    grant_dc     = dc_req_valid && (!ic_req_valid || rr);
    req_valid    = grant_dc ? dc_req_valid : ic_req_valid;
    mem_req_addr = grant_dc ? dc_req_addr : ic_req_addr;
    mem_req_tag  = grant_dc ? {1'b1, dc_req_tag} : {1'b0, ic_req_tag};
    mem_req_rw   = grant_dc && dc_req_rw;

    // Reset gating keeps every handshake output low while reset is held.
    if (!reset) begin
      unique case (state)
        IDLE: begin
          mem_req_valid = req_valid;
          ic_req_ready  = !grant_dc && mem_req_ready;
          dc_req_ready  = grant_dc && mem_req_ready;
          if (req_valid && mem_req_ready) begin
            rr_next = !grant_dc;
            if (grant_dc && dc_req_rw) begin
              state_next    = WDATA;
              beat_cnt_next = '0;
            end
          end
        end
        WDATA: begin
          mem_req_data_valid = dc_req_data_valid;
          dc_req_data_ready  = mem_req_data_ready;
          if (dc_req_data_valid && mem_req_data_ready) begin
            beat_cnt_next = beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign mem_req_data_bits = dc_req_data_bits;
  assign mem_req_data_mask = dc_req_data_mask;

  // Responses carry the client id in the tag MSB; there is no backpressure.
  assign ic_resp_valid = !reset && mem_resp_valid && !mem_resp_tag[TAG_BITS-1];
  assign dc_resp_valid = !reset && mem_resp_valid &&  mem_resp_tag[TAG_BITS-1];
  assign ic_resp_tag   = mem_resp_tag[TAG_BITS-2:0];
  assign dc_resp_tag   = mem_resp_tag[TAG_BITS-2:0];
  assign ic_resp_data  = mem_resp_data;
  assign dc_resp_data  = mem_resp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: request scoreboard for grants, write-beat
// scoreboard for the data phase, plus reset and response-routing checks.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         ic_req_valid, ic_req_ready;
  logic [27:0]  ic_req_addr;
  logic [3:0]   ic_req_tag;
  logic         ic_resp_valid;
  logic [3:0]   ic_resp_tag;
  logic [127:0] ic_resp_data;
  logic         dc_req_valid, dc_req_ready, dc_req_rw;
  logic [27:0]  dc_req_addr;
  logic [3:0]   dc_req_tag;
  logic         dc_req_data_valid, dc_req_data_ready;
  logic [127:0] dc_req_data_bits;
  logic [15:0]  dc_req_data_mask;
  logic         dc_resp_valid;
  logic [3:0]   dc_resp_tag;
  logic [127:0] dc_resp_data;
  logic         mem_req_valid, mem_req_ready, mem_req_rw;
  logic [27:0]  mem_req_addr;
  logic [4:0]   mem_req_tag;
  logic         mem_req_data_valid, mem_req_data_ready;
  logic [127:0] mem_req_data_bits;
  logic [15:0]  mem_req_data_mask;
  logic         mem_resp_valid;
  logic [4:0]   mem_resp_tag;
  logic [127:0] mem_resp_data;

  typedef struct {
    logic [4:0]  tag;
    logic [27:0] addr;
    logic        rw;
  } req_t;

  req_t         req_q[$];
  logic [127:0] beat_q[$];
  int           tests = 0;
  int           fails = 0;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready),
    .ic_req_addr(ic_req_addr), .ic_req_tag(ic_req_tag),
    .ic_resp_valid(ic_resp_valid), .ic_resp_tag(ic_resp_tag), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
    .dc_req_addr(dc_req_addr), .dc_req_tag(dc_req_tag),
    .dc_req_data_valid(dc_req_data_valid), .dc_req_data_ready(dc_req_data_ready),
    .dc_req_data_bits(dc_req_data_bits), .dc_req_data_mask(dc_req_data_mask),
    .dc_resp_valid(dc_resp_valid), .dc_resp_tag(dc_resp_tag), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [6:0] handshake_outs();
    return {ic_req_ready, ic_resp_valid, dc_req_ready, dc_req_data_ready,
            dc_resp_valid, mem_req_valid, mem_req_data_valid};
  endfunction

  task automatic expect_req(input logic [4:0] tag, input logic [27:0] addr, input logic rw);
    req_t e;
    e.tag = tag; e.addr = addr; e.rw = rw;
    req_q.push_back(e);
  endtask

  task automatic check_req(input string name);
    req_t e;
    chk({name, "_fire"}, {mem_req_valid, mem_req_ready}, 2'b11);
    if (req_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s_queue: observed empty expected entry", name);
    end else begin
      e = req_q.pop_front();
      chk({name, "_tag"},  mem_req_tag,  e.tag);
      chk({name, "_addr"}, mem_req_addr, e.addr);
      chk({name, "_rw"},   mem_req_rw,   e.rw);
    end
  endtask

  initial begin
    logic [5:0]   pat;
    logic [127:0] bdata;
    logic [15:0]  bmask;
    int           beats;

    reset = 1'b1;
    ic_req_valid = 1'b1; ic_req_addr = 28'h0; ic_req_tag = 4'h0;
    dc_req_valid = 1'b1; dc_req_rw = 1'b0; dc_req_addr = 28'h0; dc_req_tag = 4'h0;
    dc_req_data_valid = 1'b1; dc_req_data_bits = '0; dc_req_data_mask = '0;
    mem_req_ready = 1'b1; mem_req_data_ready = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_tag = 5'h10; mem_resp_data = '0;

    smp();
    chk("reset_outs", handshake_outs(), 7'h00);
    chk("reset_rr", dut.rr, 1'b0);

    // Both clients read together: ic, dc, ic, dc.
    cyc();
    reset = 1'b0; mem_resp_valid = 1'b0; dc_req_data_valid = 1'b0;
    ic_req_addr = 28'h100; ic_req_tag = 4'h3;
    dc_req_addr = 28'h200; dc_req_tag = 4'h5;
    expect_req({1'b0, 4'h3}, 28'h100, 1'b0);
    smp();
    check_req("rr_ic0");
    chk("rr_ic0_readies", {ic_req_ready, dc_req_ready}, 2'b10);
    chk("rr_ic0_no_data", mem_req_data_valid, 1'b0);
    cyc();
    expect_req({1'b1, 4'h5}, 28'h200, 1'b0);
    smp();
    check_req("rr_dc0");
    chk("rr_dc0_readies", {ic_req_ready, dc_req_ready}, 2'b01);
    cyc();
    expect_req({1'b0, 4'h3}, 28'h100, 1'b0);
    smp();
    check_req("rr_ic1");
    cyc();
    expect_req({1'b1, 4'h5}, 28'h200, 1'b0);
    smp();
    check_req("rr_dc1");

    // ic alone, stalled three cycles; rr must hold until acceptance.
    cyc();
    dc_req_valid = 1'b0; mem_req_ready = 1'b0;
    ic_req_addr = 28'h300; ic_req_tag = 4'h9;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("stall_valid", mem_req_valid, 1'b1);
      chk("stall_ready", ic_req_ready, 1'b0);
      chk("stall_rr", dut.rr, 1'b0);
      cyc();
    end
    mem_req_ready = 1'b1;
    expect_req({1'b0, 4'h9}, 28'h300, 1'b0);
    smp();
    check_req("stall_accept");
    cyc();
    ic_req_valid = 1'b0;
    smp();
    chk("stall_rr_after", dut.rr, 1'b1);
    chk("idle_no_valid", mem_req_valid, 1'b0);

    // dc write at 0x10 with ic waiting; data-ready pattern 1,0,1,1,0,1.
    cyc();
    dc_req_valid = 1'b1; dc_req_rw = 1'b1; dc_req_addr = 28'h10; dc_req_tag = 4'h7;
    ic_req_valid = 1'b1; ic_req_addr = 28'h400; ic_req_tag = 4'h2;
    dc_req_data_valid = 1'b1; dc_req_data_bits = {4{32'hAAAA_0000}};
    expect_req({1'b1, 4'h7}, 28'h10, 1'b1);
    smp();
    check_req("wr_accept");
    chk("wr_accept_no_beat", {mem_req_data_valid, dc_req_data_ready}, 2'b00);
    cyc();
    dc_req_valid = 1'b0;
    pat = 6'b101101;
    beats = 0;
    for (int i = 0; i < 6; i++) begin
      mem_req_data_ready = pat[i];
      bdata = {4{32'hD000_0000 + 32'(i)}};
      bmask = 16'hFFFF ^ 16'(i);
      dc_req_data_bits = bdata;
      dc_req_data_mask = bmask;
      if (pat[i]) beat_q.push_back(bdata);
      if (i == 2) begin
        mem_resp_valid = 1'b1; mem_resp_tag = 5'h0A; mem_resp_data = 128'hC0FFEE;
      end
      smp();
      chk("wdata_block", {mem_req_valid, ic_req_ready, dc_req_ready}, 3'b000);
      chk("wdata_valid", mem_req_data_valid, 1'b1);
      chk("wdata_ready", dc_req_data_ready, pat[i]);
      chk("wdata_mask", mem_req_data_mask, bmask);
      if (mem_req_data_valid && mem_req_data_ready) begin
        beats++;
        if (beat_q.size() > 0) chk("wdata_bits", mem_req_data_bits, beat_q.pop_front());
      end
      if (i == 2) begin
        chk("wdata_resp_ic", {ic_resp_valid, dc_resp_valid}, 2'b10);
        chk("wdata_resp_tag", ic_resp_tag, 4'hA);
        chk("wdata_resp_data", ic_resp_data, 128'hC0FFEE);
      end
      cyc();
      mem_resp_valid = 1'b0;
    end
    chk("wdata_beats", beats, 4);
    chk("wdata_beats_left", beat_q.size(), 0);
    expect_req({1'b0, 4'h2}, 28'h400, 1'b0);
    smp();
    check_req("wr_done_ic");
    chk("wr_done_closed", {mem_req_data_valid, dc_req_data_ready}, 2'b00);

    // dc response coinciding with an ic request.
    cyc();
    dc_req_data_valid = 1'b0;
    ic_req_addr = 28'h500; ic_req_tag = 4'h1;
    mem_resp_valid = 1'b1; mem_resp_tag = 5'b10011;
    mem_resp_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    expect_req({1'b0, 4'h1}, 28'h500, 1'b0);
    smp();
    check_req("resp_req");
    chk("resp_route", {dc_resp_valid, ic_resp_valid}, 2'b10);
    chk("resp_tag", dc_resp_tag, 4'h3);
    chk("resp_data", dc_resp_data, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);

    // Reset in the middle of a write after two beats.
    cyc();
    mem_resp_valid = 1'b0; ic_req_valid = 1'b0;
    dc_req_valid = 1'b1; dc_req_rw = 1'b1; dc_req_addr = 28'h20; dc_req_tag = 4'hE;
    dc_req_data_valid = 1'b1; mem_req_data_ready = 1'b1;
    expect_req({1'b1, 4'hE}, 28'h20, 1'b1);
    smp();
    check_req("rst_wr_accept");
    cyc();
    dc_req_valid = 1'b0;
    ic_req_valid = 1'b1; ic_req_addr = 28'h600; ic_req_tag = 4'h6;
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("rst_wr_beat", {mem_req_data_valid, dc_req_data_ready}, 2'b11);
      chk("rst_wr_ic_blocked", ic_req_ready, 1'b0);
      cyc();
    end
    reset = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_tag = 5'h00;
    #1;
    chk("rst_mid_outs_now", handshake_outs(), 7'h00);
    smp();
    chk("rst_mid_outs", handshake_outs(), 7'h00);
    chk("rst_mid_state", dut.state, 1'b0);
    chk("rst_mid_cnt", dut.beat_cnt, 2'd0);
    cyc();
    reset = 1'b0; mem_resp_valid = 1'b0;
    dc_req_valid = 1'b1; dc_req_rw = 1'b0; dc_req_addr = 28'h700; dc_req_tag = 4'h8;
    expect_req({1'b0, 4'h6}, 28'h600, 1'b0);
    smp();
    check_req("rst_ic_first");
    chk("rst_no_wdata", {mem_req_data_valid, dc_req_data_ready}, 2'b00);
    cyc();
    ic_req_valid = 1'b0;
    expect_req({1'b1, 4'h8}, 28'h700, 1'b0);
    smp();
    check_req("rst_dc_next");
    cyc();
    dc_req_valid = 1'b0; dc_req_data_valid = 1'b0;
    smp();
    chk("req_q_left", req_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters (one per line: name, default, meaning) SHALL be:
- ADDR_BITS, 28, memory line-address width
- DATA_BITS, 128, data beat width
- TAG_BITS, 5, downstream tag width
- WR_BEATS, 4, data beats per write request
REQ-002 Ports (one per line: name, direction, width, meaning) SHALL be:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- ic_req_valid / ic_req_ready  in / out  1 / 1  instruction client request handshake (read-only)
- ic_req_addr  in  ADDR_BITS  instruction client line address
- ic_req_tag  in  TAG_BITS-1  instruction client tag
- ic_resp_valid / ic_resp_tag / ic_resp_data  out  1 / TAG_BITS-1 / DATA_BITS  instruction client response
- dc_req_valid / dc_req_ready / dc_req_rw  in / out / in  1 each  data client request; rw=1 means write
- dc_req_addr / dc_req_tag  in  ADDR_BITS / TAG_BITS-1  data client address and tag
- dc_req_data_valid / dc_req_data_ready  in / out  1 each  data client write-data handshake
- dc_req_data_bits / dc_req_data_mask  in  DATA_BITS / DATA_BITS/8  data client write data and byte mask
- dc_resp_valid / dc_resp_tag / dc_resp_data  out  1 / TAG_BITS-1 / DATA_BITS  data client response
- mem_req_valid / mem_req_ready / mem_req_rw  out / in / out  1 each  downstream request
- mem_req_addr / mem_req_tag  out  ADDR_BITS / TAG_BITS  downstream address and tag
- mem_req_data_valid / mem_req_data_ready  out / in  1 each  downstream write-data handshake
- mem_req_data_bits / mem_req_data_mask  out  DATA_BITS / DATA_BITS/8  downstream write data and mask
- mem_resp_valid / mem_resp_tag / mem_resp_data  in  1 / TAG_BITS / DATA_BITS  downstream response; no backpressure

Function
REQ-003 States SHALL be IDLE and WDATA.
REQ-004 In IDLE, the grant SHALL be combinational:
- only one client valid: that client is granted
- both clients valid: the client selected by round-robin pointer rr is granted (rr=0 means ic)
REQ-005 mem_req_valid SHALL equal the granted client's valid; the granted client's ready SHALL equal mem_req_ready; the non-granted client's ready SHALL be 0.
REQ-006 mem_req_tag SHALL be {client_id, client_tag}, with ic=0 and dc=1; mem_req_rw SHALL be 0 for ic and dc_req_rw for dc.
REQ-007 On an accepted request (valid and ready high in the same cycle), rr SHALL be set to point at the other client.
REQ-008 On an accepted dc write:
- state goes IDLE to WDATA and the beat counter is cleared to 0
- the write-data path is open only in WDATA, so zero beats transfer in the accept cycle
REQ-009 In WDATA:
- mem_req_valid=0 and both client readies=0
- mem_req_data_valid=dc_req_data_valid, dc_req_data_ready=mem_req_data_ready, and data/mask pass through
- each data handshake increments the counter
- the handshake at count WR_BEATS-1 returns the state to IDLE on the next edge
REQ-010 Outside WDATA, mem_req_data_valid and dc_req_data_ready SHALL be 0.
REQ-011 Responses SHALL be routed by mem_resp_tag[TAG_BITS-1]:
- 0: ic_resp_valid=mem_resp_valid
- 1: dc_resp_valid=mem_resp_valid
- tag low bits and data pass through to both clients combinationally, with 0 cycles of latency
REQ-012 A response SHALL be delivered even when it coincides with a request or a WDATA beat.
REQ-013 A client that drops valid before it is accepted SHALL be ignored; rr SHALL NOT change without an acceptance.

Reset
REQ-014 While reset=1, the block SHALL hold state=IDLE, rr=0 and counter=0, and force every valid and ready output to 0.
REQ-015 Reset asserted in WDATA SHALL abort the write; after reset, arbitration SHALL restart in IDLE with ic first.

Verification
REQ-016 Both clients issue reads together from reset, mem_req_ready=1:
- ic is granted first with tag {0,t}, then dc with {1,t}, then ic again
REQ-017 dc write at addr 0x10, 4 beats, with mem_req_data_ready toggling 1,0,1,1,0,1:
- exactly 4 data beats pass
- ic is blocked throughout WDATA
- IDLE returns the cycle after the 4th beat
REQ-018 mem_resp_valid=1 with tag 5'b10011:
- dc_resp_valid=1 with dc_resp_tag=4'b0011
- ic_resp_valid=0 in the same cycle
REQ-019 Reset asserted after 2 of 4 write beats:
- all outputs are 0 immediately
- after release, a waiting ic read is granted first
REQ-020 Only ic is valid, with mem_req_ready=0 for 3 cycles:
- mem_req_valid is held and ic_req_ready=0 for those 3 cycles
- rr is unchanged until acceptance in cycle 4
